// File: rtl/msk_share_pkg.sv
// Shared definitions for the masked share deserializer: FSM state encoding,
// index-width helper and the share-interleave bit mapping.
package msk_share_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Width of the share index counter: at least one bit, even for d = 1.
  function automatic int idx_width(input int d);
    int w;
    w = $clog2(d);
    return (w < 1) ? 1 : w;
  endfunction

  // Position of bit i of share j on the interleaved bus.
  function automatic int ilv_index(input int i, input int j, input int d);
    return i * d + j;
  endfunction

endpackage

// File: rtl/msk_share_slot.sv
// One share register of the deserializer. Each share lives in its own
// register so that shares are never combined inside this block.
module msk_share_slot #(
  parameter int count = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             clr,
  input  logic [count-1:0] din,
  output logic [count-1:0] q
);

  // Share storage: clear wins over write (they never coincide in practice).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (we) begin
      q <= din;
    end
  end

endmodule

// File: rtl/msk_share_deserializer.sv
// Masked share deserializer: collects d shares of a count-bit value, one
// share per beat, and presents them as a share-interleaved count*d bus
// (bit i of share j at index i*d+j) with a valid/ready handshake.
// Optional build macro: MSK_SHARE_ZEROIZE_EN clears all share registers on
// the output handshake so stale shares do not persist after handoff.
module msk_share_deserializer
  import msk_share_pkg::*;
#(
  parameter int d     = 2,
  parameter int count = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_first,
  input  logic [count-1:0]   in_share,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [count*d-1:0] out_data,
  output logic               sync_err
);

  localparam int             IW   = idx_width(d);
  localparam logic [IW-1:0]  LAST = IW'(d - 1);

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   wr_slot;
  logic            accept;
  logic            handshake;
  logic            last_beat;
  logic            clr;
  logic [d-1:0]    we;
  logic [count-1:0] share_q [d];

  // No bypass: in_ready is a pure decode of the state register.
  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;

  // A first-share beat always restarts the group at slot 0.
  assign wr_slot   = in_first ? '0 : idx;
  assign last_beat = (wr_slot == LAST);

`ifdef MSK_SHARE_ZEROIZE_EN
  assign clr = handshake;
`else
  assign clr = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: complete a group into HOLD, release on handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (accept && last_beat) state_nxt = HOLD;
      HOLD:    if (handshake)           state_nxt = COLLECT;
    endcase
  end

  // Share index counter and one-cycle resynchronisation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= accept & in_first & (idx != '0);
      if (accept) begin
        idx <= last_beat ? '0 : wr_slot + 1'b1;
      end
    end
  end

  // Per-share registers and interleave wiring straight to the output port.
  for (genvar j = 0; j < d; j++) begin : g_slot
    assign we[j] = accept && (wr_slot == IW'(j));

    msk_share_slot #(
      .count(count)
    ) u_slot (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (we[j]),
      .clr  (clr),
      .din  (in_share),
      .q    (share_q[j])
    );

    for (genvar i = 0; i < count; i++) begin : g_bit
      assign out_data[ilv_index(i, j, d)] = share_q[j][i];
    end
  end

endmodule

// File: tb/tb_msk_share_deserializer.sv
// Scoreboard bench for msk_share_deserializer (d=2, count=8).
module tb_msk_share_deserializer;

  localparam int D   = 2;
  localparam int CNT = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_first = 1'b0;
  logic [CNT-1:0]  in_share = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [CNT*D-1:0] out_data;
  logic            sync_err;

  int tests = 0;
  int fails = 0;
  int xfers = 0;
  logic [15:0] sb[$];
  logic [15:0] mon_exp;
  logic [15:0] bp_exp;

  msk_share_deserializer #(
    .d    (D),
    .count(CNT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_first (in_first),
    .in_share (in_share),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference interleave: bit i of share j at index i*2+j.
  function automatic logic [15:0] ilv(input logic [7:0] s0, input logic [7:0] s1);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i*2]   = s0[i];
      r[i*2+1] = s1[i];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] share, input logic first);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_share = share;
    in_first = first;
    tick();
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  // Monitor: a transfer happens at the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      xfers++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_xfer: got %0h, expected no transfer", out_data);
      end else begin
        mon_exp = sb.pop_front();
        check("xfer_data", 32'(out_data), 32'(mon_exp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and release
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_data",  32'(out_data),  32'h0000);
    check("rst_sync_err",  32'(sync_err),  32'd0);
    tick();

    // Group load: A5 then 3C
    out_ready = 1'b1;
    send(8'hA5, 1'b1);
    check("load_not_early", 32'(out_valid), 32'd0);
    send(8'h3C, 1'b0);
    sb.push_back(16'h4EB1);
    check("load_valid",    32'(out_valid), 32'd1);
    check("load_data",     32'(out_data),  32'h4EB1);
    check("load_in_ready", 32'(in_ready),  32'd0);
    tick();
    check("after_xfer_in_ready",  32'(in_ready),  32'd1);
    check("after_xfer_out_valid", 32'(out_valid), 32'd0);
`ifdef MSK_SHARE_ZEROIZE_EN
    check("zeroize_data", 32'(out_data), 32'h0000);
`else
    check("retain_data",  32'(out_data), 32'h4EB1);
`endif

    // Backpressure: hold for 5 cycles while a beat is offered
    out_ready = 1'b0;
    send(8'h5A, 1'b1);
    send(8'hC3, 1'b0);
    bp_exp = ilv(8'h5A, 8'hC3);
    sb.push_back(bp_exp);
    in_valid = 1'b1;
    in_share = 8'hFF;
    in_first = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_data",  32'(out_data),  32'(bp_exp));
      tick();
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_released_valid", 32'(out_valid), 32'd0);
    check("bp_released_ready", 32'(in_ready),  32'd1);
    repeat (2) tick();
    check("bp_one_xfer", 32'(xfers), 32'd2);

    // Resynchronisation: 11(first), 22(first), 33
    out_ready = 1'b1;
    send(8'h11, 1'b1);
    check("resync_no_err_idx0", 32'(sync_err), 32'd0);
    send(8'h22, 1'b1);
    check("resync_err_pulse", 32'(sync_err), 32'd1);
    send(8'h33, 1'b0);
    sb.push_back(16'h0E0E);
    check("resync_err_once",  32'(sync_err),  32'd0);
    check("resync_valid",     32'(out_valid), 32'd1);
    check("resync_data",      32'(out_data),  32'h0E0E);
    tick();
    check("resync_in_ready",  32'(in_ready),  32'd1);

    // Asynchronous reset while holding a complete group
    out_ready = 1'b0;
    send(8'h77, 1'b1);
    send(8'h88, 1'b0);
    check("pre_rst_hold_valid", 32'(out_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_hold_valid",    32'(out_valid), 32'd0);
    check("rst_hold_in_ready", 32'(in_ready),  32'd1);
    check("rst_hold_data",     32'(out_data),  32'h0000);
    #2 rst_n = 1'b1;
    tick();

    // Asynchronous reset mid-collection discards the partial group
    send(8'h77, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_data",  32'(out_data),  32'h0000);
    #2 rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send(8'h99, 1'b0);
    check("post_rst_idx0", 32'(out_valid), 32'd0);
    send(8'h66, 1'b0);
    sb.push_back(ilv(8'h99, 8'h66));
    check("post_rst_valid", 32'(out_valid), 32'd1);
    tick();
    out_ready = 1'b0;
    repeat (2) tick();

    check("total_xfers",    32'(xfers),     32'd4);
    check("sb_drained",     32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
